// File: rtl/sort_pkg.sv
// Shared types and helpers for the bubble-sort datapath (loader and sorter bench).
package sort_pkg;

  // Loader handshake phases: collect words, pulse start, wait for the sorter.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } loader_state_e;

  localparam int unsigned PAD_MAX_W = 64;

  // Pad word for unused slots: all ones, so pads sort to the top of the array.
  function automatic logic [PAD_MAX_W-1:0] pad_val(input int unsigned size_data);
    return {PAD_MAX_W{1'b1}} >> (PAD_MAX_W - size_data);
  endfunction

  // Bits needed to hold a count of 0..num_vals.
  function automatic int unsigned cnt_width(input int unsigned num_vals);
    return $clog2(num_vals + 1);
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Registered rising-edge detector: flags a 0->1 transition of din.
module edge_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c
);

  logic din_q;

  // Remember last sampled level of din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) din_q <= 1'b0;
    else     din_q <= din;
  end

  assign rise_c = din & ~din_q;

endmodule

// File: rtl/sort_input_loader.sv
// Collects a batch of stream words into the sorter's packed input vector,
// pads short batches, pulses start and holds data until the sorter is done.
module sort_input_loader
  import sort_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 8,
  parameter int unsigned NUM_VALS  = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_valid,
  input  logic [SIZE_DATA-1:0]                i_data,
  input  logic                                i_last,
  output logic                                o_ready,
  output logic [NUM_VALS-1:0][SIZE_DATA-1:0]  o_data,
  output logic                                o_start,
  input  logic                                i_done,
  output logic [$clog2(NUM_VALS+1)-1:0]       o_count,
  output logic                                o_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_VALS);
  localparam int unsigned CNT_W = cnt_width(NUM_VALS);
  localparam logic [SIZE_DATA-1:0] PAD_WORD = SIZE_DATA'(pad_val(SIZE_DATA));

  loader_state_e                       state_q, state_n;
  logic [IDX_W-1:0]                    idx_q, idx_n;
  logic [NUM_VALS-1:0][SIZE_DATA-1:0]  data_n;
  logic [CNT_W-1:0]                    count_n;
  logic                                start_n;
  logic                                busy_n;
  logic                                close_c;
  logic                                done_rise_c;

  // Only a fresh rising edge of done may release a waiting batch.
  edge_rise_det u_done_edge (
    .clk    (i_clk),
    .rst    (i_rst),
    .din    (i_done),
    .rise_c (done_rise_c)
  );

  // Ready is a pure function of state, forced low during reset.
  assign o_ready = (state_q == FILL) & ~i_rst;

  // Next-state and next-output computation.
  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    data_n  = o_data;
    count_n = o_count;
    start_n = 1'b0;
    busy_n  = 1'b0;
    close_c = (idx_q == IDX_W'(NUM_VALS - 1)) | i_last;

    case (state_q)
      FILL: begin
        if (i_valid) begin
          for (int i = 0; i < int'(NUM_VALS); i++) begin
            if (IDX_W'(i) == idx_q) begin
              data_n[i] = i_data;
            end else if (close_c && (IDX_W'(i) > idx_q)) begin
              data_n[i] = PAD_WORD;
            end
          end
          count_n = CNT_W'(idx_q) + CNT_W'(1);
          if (close_c) begin
            state_n = START;
            start_n = 1'b1;
          end else begin
            idx_n = idx_q + IDX_W'(1);
          end
        end
      end
      START: begin
        state_n = WAIT;
        busy_n  = 1'b1;
      end
      WAIT: begin
        if (done_rise_c) begin
          state_n = FILL;
          idx_n   = '0;
          count_n = '0;
        end else begin
          busy_n = 1'b1;
        end
      end
      default: begin
        state_n = FILL;
        idx_n   = '0;
        count_n = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      o_data  <= '0;
      o_count <= '0;
      o_start <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      o_data  <= data_n;
      o_count <= count_n;
      o_start <= start_n;
      o_busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_sort_input_loader.sv
// Self-checking bench for sort_input_loader with NUM_VALS=4, SIZE_DATA=8.
module tb_sort_input_loader;

  localparam int unsigned SD = 8;
  localparam int unsigned NV = 4;

  logic                 i_clk;
  logic                 i_rst;
  logic                 i_valid;
  logic [SD-1:0]        i_data;
  logic                 i_last;
  logic                 o_ready;
  logic [NV-1:0][SD-1:0] o_data;
  logic                 o_start;
  logic                 i_done;
  logic [2:0]           o_count;
  logic                 o_busy;

  int n_tests;
  int n_fail;

  sort_input_loader #(.SIZE_DATA(SD), .NUM_VALS(NV)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_start (o_start),
    .i_done  (i_done),
    .o_count (o_count),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          n;
    logic [31:0] words;
    bit          last_full;
    bit          hold_aa;
    bit          keep_high;
    logic [31:0] exp_data;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: real words in arrival order, then all-ones pads up to NV slots.
  function automatic logic [31:0] model_vec(input logic [31:0] words, input int n);
    logic [7:0] q[$];
    logic [31:0] v;
    for (int k = 0; k < n; k++) q.push_back(words[k*8 +: 8]);
    while (q.size() < NV) q.push_back(8'hFF);
    for (int i = 0; i < int'(NV); i++) v[i*8 +: 8] = q[i];
    return v;
  endfunction

  // Stream one batch in and check start pulse, data, count and hand-off.
  task automatic load_batch(input logic [31:0] words, input int n, input bit last_full,
                            input bit gaps, input bit hold_aa,
                            input logic [31:0] exp_data, input int exp_cnt);
    for (int k = 0; k < n; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        i_valid = 1'b0;
        i_last  = 1'($urandom_range(0, 1));
        i_data  = 8'($urandom);
        @(negedge i_clk);
        check("gap_no_start", 32'(o_start), 32'd0);
        check("gap_ready", 32'(o_ready), 32'd1);
        check("gap_count", 32'(o_count), 32'(k));
      end
      i_valid = 1'b1;
      i_data  = words[k*8 +: 8];
      i_last  = (k == n - 1) && ((n < int'(NV)) || last_full);
      check("fill_ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      if (k < n - 1) begin
        check("no_early_start", 32'(o_start), 32'd0);
        check("partial_count", 32'(o_count), 32'(k + 1));
      end
    end
    check("start_pulse", 32'(o_start), 32'd1);
    check("start_data", 32'(o_data), exp_data);
    check("start_count", 32'(o_count), 32'(exp_cnt));
    check("start_ready", 32'(o_ready), 32'd0);
    check("start_busy", 32'(o_busy), 32'd0);
    if (hold_aa) begin
      i_valid = 1'b1;
      i_data  = 8'hAA;
      i_last  = 1'b1;
    end else begin
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
    @(negedge i_clk);
    check("start_one_cycle", 32'(o_start), 32'd0);
    check("wait_busy", 32'(o_busy), 32'd1);
    check("wait_ready", 32'(o_ready), 32'd0);
    check("wait_data", 32'(o_data), exp_data);
    repeat ($urandom_range(0, 3)) begin
      @(negedge i_clk);
      check("wait_hold_busy", 32'(o_busy), 32'd1);
      check("wait_hold_data", 32'(o_data), exp_data);
      check("wait_hold_count", 32'(o_count), 32'(exp_cnt));
    end
  endtask

  // Release the waiting batch with a fresh done rising edge.
  task automatic finish_batch(input bit keep_high, input logic [31:0] exp_data);
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (i_done) begin
      repeat (2) begin
        @(negedge i_clk);
        check("busy_done_held", 32'(o_busy), 32'd1);
      end
      i_done = 1'b0;
      @(negedge i_clk);
      check("busy_after_drop", 32'(o_busy), 32'd1);
    end
    i_done = 1'b1;
    @(negedge i_clk);
    check("exit_busy", 32'(o_busy), 32'd0);
    check("exit_ready", 32'(o_ready), 32'd1);
    check("exit_count", 32'(o_count), 32'd0);
    check("data_kept", 32'(o_data), exp_data);
    if (!keep_high) i_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [31:0] e;
    int n;
    n_tests = 0;
    n_fail  = 0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_done  = 1'b0;

    tbl[0] = '{4, 32'h20401030, 1'b0, 1'b1, 1'b1, 32'h20401030, 4};
    tbl[1] = '{2, 32'h00000205, 1'b0, 1'b0, 1'b0, 32'hFFFF0205, 2};
    tbl[2] = '{1, 32'h00000007, 1'b0, 1'b1, 1'b0, 32'hFFFFFF07, 1};
    tbl[3] = '{4, 32'h7F80FE01, 1'b1, 1'b0, 1'b0, 32'h7F80FE01, 4};

    repeat (2) @(negedge i_clk);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_start", 32'(o_start), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_ready", 32'(o_ready), 32'd1);

    for (int t = 0; t < 4; t++) begin
      load_batch(tbl[t].words, tbl[t].n, tbl[t].last_full, 1'b0, tbl[t].hold_aa,
                 tbl[t].exp_data, tbl[t].exp_cnt);
      finish_batch(tbl[t].keep_high, tbl[t].exp_data);
    end

    // Reset in the middle of a batch discards the partial words.
    i_valid = 1'b1;
    i_last  = 1'b0;
    i_data  = 8'h55;
    @(negedge i_clk);
    i_data  = 8'h66;
    @(negedge i_clk);
    check("mid_count", 32'(o_count), 32'd2);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    #1;
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    check("mid_rst_data", 32'(o_data), 32'd0);
    check("mid_rst_count", 32'(o_count), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    load_batch(32'h44332211, 4, 1'b0, 1'b0, 1'b0, 32'h44332211, 4);
    finish_batch(1'b0, 32'h44332211);

    // Randomized batches against the reference model.
    for (int b = 0; b < 40; b++) begin
      n = int'($urandom_range(1, 4));
      w = 32'($urandom);
      e = model_vec(w, n);
      load_batch(w, n, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), e, n);
      finish_batch(1'($urandom_range(0, 1)), e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
